// File: rtl/full_datapath.sv
// -----------------------------------------------------------------------------
// full_datapath
//   Single-cycle RV32I-subset processor datapath for FPGA board bring-up.
//   Holds the PC, a 64x32 instruction ROM with a small built-in test program,
//   a 32x32 register file, the ALU and a 64x32 word-addressed data RAM.
//   Debug taps drive 16 LEDs and a 4-digit multiplexed seven-segment display.
//
// Ports
//   clk      in   1   sole clock, all state updates on the rising edge
//   rst      in   1   asynchronous reset, active low
//   ssdClk   in   1   digit-scan advance strobe, sampled on clk
//   ledSel   in   2   LED debug source select
//   ssdSel   in   4   seven-segment debug source select
//   LEDs     out  16  debug LEDs
//   LED_out  out  7   segments {g,f,e,d,c,b,a}, active low
//   Anode    out  4   digit enables, active low, one-hot
//
// Configuration
//   RV_MEXT_EN  when defined, R-type funct7=0000001 funct3=000 executes MUL
//               (low 32 bits of the product); otherwise that encoding is a NOP.
// -----------------------------------------------------------------------------
module full_datapath #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ssdClk,
    input  logic [1:0]  ledSel,
    input  logic [3:0]  ssdSel,
    output logic [15:0] LEDs,
    output logic [6:0]  LED_out,
    output logic [3:0]  Anode
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_MUL  = 4'd6,
        ALU_PASS = 4'd7
    } alu_op_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] pc;
    logic [31:0] regs [0:31];
    logic [31:0] dmem [0:DMEM_DEPTH-1];
    logic [31:0] imem [0:IMEM_DEPTH-1];
    logic [1:0]  scan;

    logic [31:0] instr, imm, rs1_data, rs2_data, alu_b, alu_result;
    logic [31:0] pc_plus4, branch_target, next_pc, ram_rdata, wb_data;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    alu_op_t     alu_ctl;
    logic        reg_write, alu_src, mem_write, mem_read, mem_to_reg;
    logic        branch, jump, zero, taken;
    logic [15:0] ssd_val;
    logic [3:0]  nibble;

    // Built-in program; every unlisted word is a NOP so a wrapped PC is harmless.
    always_comb begin
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = NOP;
        imem[0] = 32'h0050_0093;   // addi x1,x0,5
        imem[1] = 32'h0030_0113;   // addi x2,x0,3
        imem[2] = 32'h0020_81B3;   // add  x3,x1,x2
        imem[3] = 32'h4020_8233;   // sub  x4,x1,x2
        imem[4] = 32'h0030_2023;   // sw   x3,0(x0)
        imem[5] = 32'h0000_2283;   // lw   x5,0(x0)
        imem[6] = 32'h0032_8463;   // beq  x5,x3,+8
        imem[7] = 32'h0010_0313;   // addi x6,x0,1
        imem[8] = 32'h0000_03EF;   // jal  x7,0
    end

    assign instr  = imem[pc[7:2]];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    // Decode: anything not explicitly recognised leaves every control low,
    // which makes it a NOP that simply advances the PC.
    always_comb begin
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_ctl    = ALU_ADD;
        imm        = 32'd0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    reg_write = 1'b1;
                    case (funct3)
                        3'b000:  alu_ctl = ALU_ADD;
                        3'b111:  alu_ctl = ALU_AND;
                        3'b110:  alu_ctl = ALU_OR;
                        3'b100:  alu_ctl = ALU_XOR;
                        3'b010:  alu_ctl = ALU_SLT;
                        default: reg_write = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    reg_write = 1'b1;
                    alu_ctl   = ALU_SUB;
                end
`ifdef RV_MEXT_EN
                else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
                    reg_write = 1'b1;
                    alu_ctl   = ALU_MUL;
                end
`endif
            end
            7'b0010011: if (funct3 == 3'b000) begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm       = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0000011: if (funct3 == 3'b010) begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                imm        = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0100011: if (funct3 == 3'b010) begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
                imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b1100011: if (funct3 == 3'b000 || funct3 == 3'b001) begin
                branch  = 1'b1;
                alu_ctl = ALU_SUB;
                imm     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'b1101111: begin
                reg_write = 1'b1;
                jump      = 1'b1;
                imm       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            7'b0110111: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctl   = ALU_PASS;
                imm       = {instr[31:12], 12'd0};
            end
            default: ;
        endcase
    end

    assign rs1_data = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_data = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign alu_b    = alu_src ? imm : rs2_data;

    always_comb begin
        case (alu_ctl)
            ALU_ADD:  alu_result = rs1_data + alu_b;
            ALU_SUB:  alu_result = rs1_data - alu_b;
            ALU_AND:  alu_result = rs1_data & alu_b;
            ALU_OR:   alu_result = rs1_data | alu_b;
            ALU_XOR:  alu_result = rs1_data ^ alu_b;
            ALU_SLT:  alu_result = {31'd0, $signed(rs1_data) < $signed(alu_b)};
            ALU_MUL:  alu_result = rs1_data * alu_b;
            ALU_PASS: alu_result = alu_b;
            default:  alu_result = 32'd0;
        endcase
    end

    // BEQ and BNE both subtract; funct3[0] picks which sense of zero branches.
    assign zero          = (alu_result == 32'd0);
    assign taken         = branch & (funct3[0] ? ~zero : zero);
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc + imm;
    assign next_pc       = (jump || taken) ? branch_target : pc_plus4;
    assign ram_rdata     = dmem[alu_result[7:2]];
    assign wb_data       = mem_to_reg ? ram_rdata : (jump ? pc_plus4 : alu_result);

    // Architectural state: PC, register file and display scan counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc   <= 32'd0;
            scan <= 2'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            pc <= next_pc;
            if (ssdClk) scan <= scan + 2'd1;
            if (reg_write && rd != 5'd0) regs[rd] <= wb_data;
        end
    end

    // Data RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_write) dmem[alu_result[7:2]] <= rs2_data;
    end

    always_comb begin
        case (ledSel)
            2'b00:   LEDs = instr[15:0];
            2'b01:   LEDs = instr[31:16];
            2'b10:   LEDs = {alu_ctl, reg_write, alu_src, mem_write, mem_read,
                             mem_to_reg, branch, jump, zero, taken, 3'b000};
            default: LEDs = pc[15:0];
        endcase
    end

    always_comb begin
        case (ssdSel)
            4'd0:    ssd_val = pc[15:0];
            4'd1:    ssd_val = pc_plus4[15:0];
            4'd2:    ssd_val = branch_target[15:0];
            4'd3:    ssd_val = next_pc[15:0];
            4'd4:    ssd_val = rs1_data[15:0];
            4'd5:    ssd_val = rs2_data[15:0];
            4'd6:    ssd_val = wb_data[15:0];
            4'd7:    ssd_val = imm[15:0];
            4'd8:    ssd_val = alu_b[15:0];
            4'd9:    ssd_val = alu_result[15:0];
            4'd10:   ssd_val = ram_rdata[15:0];
            default: ssd_val = 16'd0;
        endcase
    end

    assign nibble = ssd_val[{scan, 2'b00} +: 4];
    assign Anode  = ~(4'b0001 << scan);

    always_comb begin
        case (nibble)
            4'h0: LED_out = 7'b1000000;
            4'h1: LED_out = 7'b1111001;
            4'h2: LED_out = 7'b0100100;
            4'h3: LED_out = 7'b0110000;
            4'h4: LED_out = 7'b0011001;
            4'h5: LED_out = 7'b0010010;
            4'h6: LED_out = 7'b0000010;
            4'h7: LED_out = 7'b1111000;
            4'h8: LED_out = 7'b0000000;
            4'h9: LED_out = 7'b0010000;
            4'hA: LED_out = 7'b0001000;
            4'hB: LED_out = 7'b0000011;
            4'hC: LED_out = 7'b1000110;
            4'hD: LED_out = 7'b0100001;
            4'hE: LED_out = 7'b0000110;
            default: LED_out = 7'b0001110;
        endcase
    end

endmodule

// File: tb/tb_full_datapath.sv
// -----------------------------------------------------------------------------
// tb_full_datapath
//   Directed bench for full_datapath: walks the built-in program, checks the
//   debug taps, the display scan, the final architectural state and a
//   mid-run reset that must leave data RAM untouched.
// -----------------------------------------------------------------------------
module tb_full_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        ssdClk;
    logic [1:0]  ledSel;
    logic [3:0]  ssdSel;
    logic [15:0] LEDs;
    logic [6:0]  LED_out;
    logic [3:0]  Anode;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G8 = 7'b0000000;

    full_datapath dut (
        .clk     (clk),
        .rst     (rst),
        .ssdClk  (ssdClk),
        .ledSel  (ledSel),
        .ssdSel  (ssdSel),
        .LEDs    (LEDs),
        .LED_out (LED_out),
        .Anode   (Anode)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Clock n edges with the given scan strobe, then settle on the falling edge.
    task automatic applyStimulus(input int n, input logic scanStrobe);
        ssdClk = scanStrobe;
        repeat (n) @(posedge clk);
        @(negedge clk);
        ssdClk = 1'b0;
    endtask

    task automatic setSel(input logic [1:0] l, input logic [3:0] s);
        ledSel = l;
        ssdSel = s;
        #1;
    endtask

    initial begin
        rst    = 1'b0;
        ssdClk = 1'b0;
        ledSel = 2'b11;
        ssdSel = 4'd0;
        #2;
        $display("[TB] reset state");
        checkOutput("reset_pc", {16'd0, LEDs}, 32'h0);
        checkOutput("reset_anode", {28'd0, Anode}, 32'he);
        checkOutput("reset_seg", {25'd0, LED_out}, {25'd0, G0});
        checkOutput("reset_x1", dut.regs[1], 32'd0);

        @(negedge clk);
        rst = 1'b1;
        setSel(2'b00, 4'd4);
        checkOutput("pc0_instr_lo", {16'd0, LEDs}, 32'h0093);
        checkOutput("pc0_x0_rs1", {25'd0, LED_out}, {25'd0, G0});
        setSel(2'b01, 4'd4);
        checkOutput("pc0_instr_hi", {16'd0, LEDs}, 32'h0050);

        applyStimulus(2, 1'b0);
        setSel(2'b11, 4'd9);
        checkOutput("pc8_pc", {16'd0, LEDs}, 32'h0008);
        checkOutput("pc8_alu_result", {25'd0, LED_out}, {25'd0, G8});
        setSel(2'b00, 4'd4);
        checkOutput("pc8_instr_lo", {16'd0, LEDs}, 32'h81B3);
        checkOutput("pc8_rs1", {25'd0, LED_out}, {25'd0, G5});
        setSel(2'b00, 4'd5);
        checkOutput("pc8_rs2", {25'd0, LED_out}, {25'd0, G3});

        applyStimulus(2, 1'b0);
        setSel(2'b10, 4'd5);
        checkOutput("pc16_sw_ctl", {16'd0, LEDs}, 32'h0610);
        checkOutput("pc16_store_data", {25'd0, LED_out}, {25'd0, G8});

        applyStimulus(2, 1'b0);
        setSel(2'b10, 4'd7);
        checkOutput("pc24_beq_ctl", {16'd0, LEDs}, 32'h1058);
        checkOutput("pc24_imm", {25'd0, LED_out}, {25'd0, G8});
        setSel(2'b10, 4'd10);
        checkOutput("pc24_ram_rdata", {25'd0, LED_out}, {25'd0, G8});
        setSel(2'b10, 4'd6);
        checkOutput("pc24_wb", {25'd0, LED_out}, {25'd0, G0});

        applyStimulus(3, 1'b0);
        setSel(2'b11, 4'd0);
        checkOutput("run9_pc", {16'd0, LEDs}, 32'd32);
        checkOutput("run9_x1", dut.regs[1], 32'd5);
        checkOutput("run9_x2", dut.regs[2], 32'd3);
        checkOutput("run9_x3", dut.regs[3], 32'd8);
        checkOutput("run9_x4", dut.regs[4], 32'd2);
        checkOutput("run9_x5", dut.regs[5], 32'd8);
        checkOutput("run9_x6", dut.regs[6], 32'd0);
        checkOutput("run9_x7", dut.regs[7], 32'd36);
        checkOutput("run9_ram0", dut.dmem[0], 32'd8);

        applyStimulus(5, 1'b0);
        checkOutput("loop_pc", {16'd0, LEDs}, 32'd32);
        checkOutput("loop_x7", dut.regs[7], 32'd36);

        $display("[TB] display scan of PC=0x0020");
        checkOutput("scan0_anode", {28'd0, Anode}, 32'he);
        checkOutput("scan0_seg", {25'd0, LED_out}, {25'd0, G0});
        applyStimulus(1, 1'b1);
        checkOutput("scan1_anode", {28'd0, Anode}, 32'hd);
        checkOutput("scan1_seg", {25'd0, LED_out}, {25'd0, G2});
        applyStimulus(1, 1'b1);
        checkOutput("scan2_anode", {28'd0, Anode}, 32'hb);
        checkOutput("scan2_seg", {25'd0, LED_out}, {25'd0, G0});
        applyStimulus(1, 1'b1);
        checkOutput("scan3_anode", {28'd0, Anode}, 32'h7);
        checkOutput("scan3_seg", {25'd0, LED_out}, {25'd0, G0});
        applyStimulus(1, 1'b1);
        checkOutput("scan4_anode", {28'd0, Anode}, 32'he);
        setSel(2'b11, 4'd1);
        checkOutput("loop_pc_plus4", {25'd0, LED_out}, {25'd0, G4});
        setSel(2'b11, 4'd15);
        checkOutput("sel15_zero", {25'd0, LED_out}, {25'd0, G0});

        $display("[TB] mid-run reset");
        rst = 1'b0;
        #1;
        rst = 1'b1;
        setSel(2'b11, 4'd0);
        checkOutput("rerun_start_pc", {16'd0, LEDs}, 32'd0);
        applyStimulus(5, 1'b0);
        checkOutput("rerun_pc20", {16'd0, LEDs}, 32'd20);
        checkOutput("rerun_x4", dut.regs[4], 32'd2);
        rst = 1'b0;
        #1;
        checkOutput("midreset_pc", {16'd0, LEDs}, 32'd0);
        checkOutput("midreset_x3", dut.regs[3], 32'd0);
        checkOutput("midreset_x4", dut.regs[4], 32'd0);
        checkOutput("midreset_ram0", dut.dmem[0], 32'd8);
        checkOutput("midreset_anode", {28'd0, Anode}, 32'he);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
